// File: rtl/secure_keystore.sv
// Parametrised key/secret store: host request/response port with per-entry write-lock
// and read-protection, an unrestricted registered key port, and a multi-cycle zeroize.
module secure_keystore #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH),
    parameter logic [DEPTH*WIDTH-1:0] INIT_VALUE = '0,
    parameter logic [DEPTH-1:0] INIT_LOCK = '0,
    parameter logic [DEPTH-1:0] READ_PROTECT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic [DEPTH-1:0]  lock_status,
    input  logic [ADDR_W-1:0] key_addr,
    output logic [WIDTH-1:0]  key_out,
    input  logic              zeroize,
    output logic              busy
);

    typedef enum logic {IDLE, ZERO} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] zcnt_reg, zcnt_next;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] lock_q;

    logic             accept, req_in_range, key_in_range, wr_ok, rd_ok, zero_last;
    logic [WIDTH-1:0] req_entry, key_entry;

    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_err_reg, rsp_err_next;
    logic [WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic [WIDTH-1:0] key_out_reg, key_out_next;

    assign req_ready    = (state_reg == IDLE) && !zeroize;
    assign accept       = req_valid && req_ready;
    assign req_in_range = {1'b0, req_addr} < DEPTH_W;
    assign key_in_range = {1'b0, key_addr} < DEPTH_W;
    assign req_entry    = req_in_range ? mem_q[req_addr] : '0;
    assign key_entry    = key_in_range ? mem_q[key_addr] : '0;
    assign wr_ok        = req_in_range && !lock_q[req_addr];
    assign rd_ok        = req_in_range && !READ_PROTECT[req_addr];
    assign zero_last    = (state_reg == ZERO) && (zcnt_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            zcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            zcnt_reg  <= zcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        zcnt_next  = zcnt_reg;
        case (state_reg)
            IDLE: begin
                zcnt_next = '0;
                if (zeroize) state_next = ZERO;
            end
            ZERO: begin
                if (zcnt_reg == LAST) begin
                    state_next = IDLE;
                    zcnt_next  = '0;
                end else begin
                    zcnt_next = zcnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One register bank and lock bit per entry; zeroize has priority over host writes.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : entry_g
            logic [WIDTH-1:0] entry_reg;
            logic             lock_bit_reg;
            logic             we_host, we_zero, set_lock;

            assign we_host  = accept && req_write && wr_ok && (req_addr == ADDR_W'(gi));
            assign we_zero  = (state_reg == ZERO) && (zcnt_reg == ADDR_W'(gi));
            assign set_lock = (state_reg == IDLE) && lock_en && (lock_addr == ADDR_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       entry_reg <= INIT_VALUE[gi*WIDTH +: WIDTH];
                else if (we_zero) entry_reg <= '0;
                else if (we_host) entry_reg <= req_wdata;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)         lock_bit_reg <= INIT_LOCK[gi];
                else if (zero_last) lock_bit_reg <= 1'b0;
                else if (set_lock)  lock_bit_reg <= 1'b1;
            end

            assign mem_q[gi]  = entry_reg;
            assign lock_q[gi] = lock_bit_reg;
        end
    endgenerate

    always_comb begin
        rsp_valid_next = accept;
        rsp_err_next   = accept && (req_write ? !wr_ok : !rd_ok);
        rsp_rdata_next = (accept && !req_write && rd_ok) ? req_entry : '0;
        // Key data is withheld as soon as a zeroize is taken, not one cycle later.
        key_out_next   = ((state_reg == IDLE) && !zeroize) ? key_entry : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            key_out_reg   <= '0;
        end else begin
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
            key_out_reg   <= key_out_next;
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign key_out     = key_out_reg;
    assign lock_status = lock_q;
    assign busy        = (state_reg == ZERO);

endmodule
